add_acc: RTL and testbench

ADD_ACC -- requirements
Module: add_acc

---
 rtl/add_acc.sv | 101 ++++++++++
 tb/tb_add_acc.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/add_acc.sv
// Two-stage signed adder/accumulator: stage 1 registers the request, stage 2
// computes a+b or acc+a with saturate-or-wrap and a sticky overflow flag.
module add_acc #(
  parameter int dim = 14,
  parameter bit sat = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [dim-1:0] a,
  input  logic [dim-1:0] b,
  input  logic           mode,
  input  logic           clr,
  output logic           out_valid,
  output logic [dim-1:0] sum,
  output logic           ovf,
  output logic           ovf_sticky
);

  localparam logic [dim-1:0] MaxPos = {1'b0, {(dim-1){1'b1}}};
  localparam logic [dim-1:0] MinNeg = {1'b1, {(dim-1){1'b0}}};

  logic           s1_valid_q, s1_mode_q, s1_clr_q;
  logic [dim-1:0] s1_a_q, s1_b_q;

  logic           out_valid_q, out_valid_d;
  logic [dim-1:0] sum_q, sum_d;
  logic           ovf_q, ovf_d;
  logic           sticky_q, sticky_d;
  logic [dim-1:0] acc_q, acc_d;

  logic [dim-1:0] acc_eff, opnd_b, res;
  logic [dim:0]   raw;
  logic           raw_ovf;

  // clr is captured even without in_valid so a lone clear still reaches stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_mode_q  <= mode;
      s1_clr_q   <= clr;
      s1_a_q     <= a;
      s1_b_q     <= b;
    end
  end

  always_comb begin
    acc_eff = s1_clr_q ? '0 : acc_q;
    opnd_b  = s1_mode_q ? acc_eff : s1_b_q;
    raw     = {s1_a_q[dim-1], s1_a_q} + {opnd_b[dim-1], opnd_b};
    raw_ovf = raw[dim] ^ raw[dim-1];
    if (sat && raw_ovf) res = raw[dim] ? MinNeg : MaxPos;
    else                res = raw[dim-1:0];
  end

  always_comb begin
    out_valid_d = 1'b0;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    if (s1_valid_q) begin
      out_valid_d = 1'b1;
      sum_d       = res;
      ovf_d       = raw_ovf;
      acc_d       = s1_mode_q ? res : acc_eff;
      sticky_d    = (sticky_q & ~s1_clr_q) | raw_ovf;
    end else if (s1_clr_q) begin
      acc_d    = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign sum        = sum_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_add_acc.sv
// Directed bench for add_acc: one saturating and one wrapping instance share stimulus.
module tb_add_acc;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, mode, clr;
  logic signed [13:0] a, b;
  logic out_valid_s, ovf_s, sticky_s;
  logic out_valid_w, ovf_w, sticky_w;
  logic signed [13:0] sum_s, sum_w;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_acc #(.dim(14), .sat(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .clr(clr),
    .out_valid(out_valid_s), .sum(sum_s), .ovf(ovf_s), .ovf_sticky(sticky_s));

  add_acc #(.dim(14), .sat(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .clr(clr),
    .out_valid(out_valid_w), .sum(sum_w), .ovf(ovf_w), .ovf_sticky(sticky_w));

  // Outputs for a beat are visible right after the next drive() returns.
  task automatic drive(input logic v, input int av, input int bv, input logic m, input logic c);
    in_valid = v; a = 14'(av); b = 14'(bv); mode = m; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 100, 100, 1'b0, 1'b0);
    drive(1'b1, 200, 1, 1'b1, 1'b0);
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid_s); end
    checks++; if (sum_s !== 14'sd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", sum_s); end
    checks++; if (ovf_s !== 1'b0 || sticky_s !== 1'b0) begin errors++; $display("FAIL reset_flags: got %0b%0b want 00", ovf_s, sticky_s); end
    rst = 1'b0;
    idle();
    idle();
    checks++; if (out_valid_s !== 1'b0 || out_valid_w !== 1'b0) begin errors++; $display("FAIL reset_ignored_input: got %0b%0b want 00", out_valid_s, out_valid_w); end
  endtask

  task automatic test_basic();
    drive(1'b1, 100, -30, 1'b0, 1'b0);
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL basic_latency1: got %0b want 0", out_valid_s); end
    idle();
    checks++; if (out_valid_s !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid_s); end
    checks++; if (sum_s !== 14'sd70 || ovf_s !== 1'b0) begin errors++; $display("FAIL basic_sum: got %0d/%0b want 70/0", sum_s, ovf_s); end
    idle();
    checks++; if (out_valid_s !== 1'b0 || sum_s !== 14'sd70) begin errors++; $display("FAIL basic_hold: got %0b/%0d want 0/70", out_valid_s, sum_s); end
  endtask

  task automatic test_overflow();
    drive(1'b1, 8000, 500, 1'b0, 1'b0);
    drive(1'b1, -8192, -1, 1'b0, 1'b0);
    checks++; if (sum_s !== 14'sd8191 || ovf_s !== 1'b1 || sticky_s !== 1'b1) begin errors++; $display("FAIL ovf_pos_sat: got %0d/%0b/%0b want 8191/1/1", sum_s, ovf_s, sticky_s); end
    checks++; if (sum_w !== -14'sd7884 || ovf_w !== 1'b1) begin errors++; $display("FAIL ovf_pos_wrap: got %0d/%0b want -7884/1", sum_w, ovf_w); end
    idle();
    checks++; if (sum_s !== -14'sd8192 || ovf_s !== 1'b1) begin errors++; $display("FAIL ovf_neg_sat: got %0d/%0b want -8192/1", sum_s, ovf_s); end
    checks++; if (sum_w !== 14'sd8191 || ovf_w !== 1'b1) begin errors++; $display("FAIL ovf_neg_wrap: got %0d/%0b want 8191/1", sum_w, ovf_w); end
    drive(1'b1, 8000, 500, 1'b0, 1'b1);
    idle();
    checks++; if (sticky_s !== 1'b1 || sticky_w !== 1'b1) begin errors++; $display("FAIL clr_with_ovf_sticky: got %0b%0b want 11", sticky_s, sticky_w); end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    idle();
    checks++; if (sticky_s !== 1'b0 || out_valid_s !== 1'b0) begin errors++; $display("FAIL lone_clr: sticky/valid got %0b/%0b want 0/0", sticky_s, out_valid_s); end
  endtask

  task automatic test_accumulate();
    drive(1'b1, 5, 0, 1'b1, 1'b1);
    drive(1'b1, 7, 0, 1'b1, 1'b0);
    checks++; if (out_valid_s !== 1'b1 || sum_s !== 14'sd5) begin errors++; $display("FAIL acc_beat1: got %0b/%0d want 1/5", out_valid_s, sum_s); end
    drive(1'b1, -20, 0, 1'b1, 1'b0);
    checks++; if (out_valid_s !== 1'b1 || sum_s !== 14'sd12) begin errors++; $display("FAIL acc_beat2: got %0b/%0d want 1/12", out_valid_s, sum_s); end
    drive(1'b1, 1, 1, 1'b0, 1'b0);
    checks++; if (out_valid_s !== 1'b1 || sum_s !== -14'sd8 || sum_w !== -14'sd8) begin errors++; $display("FAIL acc_beat3: got %0d/%0d want -8/-8", sum_s, sum_w); end
    drive(1'b1, 0, 0, 1'b1, 1'b0);
    checks++; if (out_valid_s !== 1'b1 || sum_s !== 14'sd2) begin errors++; $display("FAIL acc_mode0: got %0b/%0d want 1/2", out_valid_s, sum_s); end
    idle();
    checks++; if (out_valid_s !== 1'b1 || sum_s !== -14'sd8) begin errors++; $display("FAIL acc_kept: got %0b/%0d want 1/-8", out_valid_s, sum_s); end
  endtask

  task automatic test_acc_saturate();
    drive(1'b1, 8191, 0, 1'b1, 1'b1);
    drive(1'b1, 1, 0, 1'b1, 1'b0);
    checks++; if (sum_s !== 14'sd8191 || ovf_s !== 1'b0) begin errors++; $display("FAIL accsat_load: got %0d/%0b want 8191/0", sum_s, ovf_s); end
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    checks++; if (sum_s !== 14'sd8191 || ovf_s !== 1'b1 || sticky_s !== 1'b1) begin errors++; $display("FAIL accsat_clamp: got %0d/%0b/%0b want 8191/1/1", sum_s, ovf_s, sticky_s); end
    checks++; if (sum_w !== -14'sd8192 || ovf_w !== 1'b1) begin errors++; $display("FAIL accwrap: got %0d/%0b want -8192/1", sum_w, ovf_w); end
    drive(1'b1, 3, 0, 1'b1, 1'b0);
    checks++; if (sticky_s !== 1'b0 || sticky_w !== 1'b0 || out_valid_s !== 1'b0) begin errors++; $display("FAIL accsat_clr: got %0b%0b/%0b want 00/0", sticky_s, sticky_w, out_valid_s); end
    idle();
    checks++; if (sum_s !== 14'sd3 || sum_w !== 14'sd3 || out_valid_s !== 1'b1) begin errors++; $display("FAIL accsat_after_clr: got %0d/%0d want 3/3", sum_s, sum_w); end
  endtask

  task automatic test_back_to_back();
    logic signed [13:0] va [8];
    logic signed [13:0] vb [8];
    logic signed [13:0] exp_s [8];
    logic signed [13:0] exp_w [8];
    logic exp_o [8];
    int r;
    for (int i = 0; i < 8; i++) begin
      va[i] = 14'($urandom_range(0, 16383));
      vb[i] = 14'($urandom_range(0, 16383));
      r = int'(va[i]) + int'(vb[i]);
      exp_o[i] = (r > 8191) || (r < -8192);
      exp_s[i] = (r > 8191) ? 14'sd8191 : (r < -8192) ? -14'sd8192 : 14'(r);
      exp_w[i] = r[13:0];
    end
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(1'b1, int'(va[k]), int'(vb[k]), 1'b0, 1'b0);
      else idle();
      if (k >= 1 && k <= 8) begin
        checks++; if (out_valid_s !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", k-1, out_valid_s); end
        checks++; if (sum_s !== exp_s[k-1] || ovf_s !== exp_o[k-1]) begin errors++; $display("FAIL stream_sat[%0d]: got %0d/%0b want %0d/%0b", k-1, sum_s, ovf_s, exp_s[k-1], exp_o[k-1]); end
        checks++; if (sum_w !== exp_w[k-1] || ovf_w !== exp_o[k-1]) begin errors++; $display("FAIL stream_wrap[%0d]: got %0d/%0b want %0d/%0b", k-1, sum_w, ovf_w, exp_w[k-1], exp_o[k-1]); end
      end
    end
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL stream_end: got %0b want 0", out_valid_s); end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 50, 0, 1'b1, 1'b1);
    drive(1'b1, 8000, 500, 1'b0, 1'b0);
    checks++; if (sum_s !== 14'sd50) begin errors++; $display("FAIL midrst_pre: got %0d want 50", sum_s); end
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checks++; if (out_valid_s !== 1'b0 || sum_s !== 14'sd0 || sticky_s !== 1'b0) begin errors++; $display("FAIL midrst_clear: got %0b/%0d/%0b want 0/0/0", out_valid_s, sum_s, sticky_s); end
    drive(1'b1, 4, 0, 1'b1, 1'b0);
    checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL midrst_discard: got %0b want 0", out_valid_s); end
    idle();
    checks++; if (out_valid_s !== 1'b1 || sum_s !== 14'sd4) begin errors++; $display("FAIL midrst_acc0: got %0b/%0d want 1/4", out_valid_s, sum_s); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; clr = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_accumulate();
    test_acc_saturate();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
